// File: rtl/comp_mult_op_driver.sv
// Operand source for the complex-multiplier harness: streams {x1,y1,x2,y2} from one of four pattern generators.
// op_val is registered and back-to-back on op_rdy; it holds under backpressure and stalls while MAX_OUTST results are unreturned.
module comp_mult_op_driver #(
    parameter int          DWIDTH    = 8,
    parameter int          MAX_OUTST = 64,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sw_rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [15:0]         num_ops,
    input  logic [4*DWIDTH-1:0] fixed_data,
    output logic                op_val,
    input  logic                op_rdy,
    output logic [4*DWIDTH-1:0] op_data,
    input  logic                sample,
    output logic                busy,
    output logic                done,
    output logic [15:0]         ops_sent,
    output logic [15:0]         res_rcvd
);
    localparam int          OW    = 4 * DWIDTH;
    localparam logic [15:0] MAX_O = 16'(MAX_OUTST);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [15:0]     num_q, num_d;
    logic [OW-1:0]   fixed_q, fixed_d;
    logic [31:0]     lfsr_q, lfsr_d;
    logic [15:0]     sent_q, sent_d;
    logic [15:0]     rcvd_q, rcvd_d;
    logic            op_val_q, op_val_d;
    logic [OW-1:0]   op_data_q, op_data_d;

    logic            xfer;
    logic            smp;
    logic [15:0]     outst;
    logic [15:0]     outst_d;

    function automatic logic [DWIDTH-1:0] corner_val(input logic [1:0] i);
        logic [DWIDTH-1:0] v;
        case (i)
            2'd0:    v = {1'b1, {(DWIDTH-1){1'b0}}};
            2'd1:    v = {1'b0, {(DWIDTH-1){1'b1}}};
            2'd2:    v = '1;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [OW-1:0] gen_op(input logic [1:0] m, input logic [15:0] n,
                                             input logic [31:0] l, input logic [OW-1:0] f);
        logic [OW-1:0] g;
        case (m)
            2'd0:    g = l[OW-1:0];
            2'd1:    g = {DWIDTH'(n), DWIDTH'(n + 16'd1), DWIDTH'(n + 16'd2), DWIDTH'(n + 16'd3)};
            2'd2:    g = {corner_val(n[1:0]), corner_val(n[3:2]), corner_val(n[5:4]), corner_val(n[7:6])};
            default: g = f;
        endcase
        return g;
    endfunction

    // Galois right-shift form of x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ({1'b0, l[31:1]} ^ 32'h8020_0003) : {1'b0, l[31:1]};
    endfunction

    assign xfer  = op_val_q & op_rdy;
    assign outst = sent_q - rcvd_q;
    assign smp   = sample & (outst != 16'd0);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        num_d     = num_q;
        fixed_d   = fixed_q;
        lfsr_d    = lfsr_q;
        sent_d    = sent_q;
        rcvd_d    = rcvd_q + {15'd0, smp};
        op_val_d  = op_val_q;
        op_data_d = op_data_q;
        outst_d   = outst;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    num_d   = num_ops;
                    fixed_d = fixed_data;
                    lfsr_d  = LFSR_SEED;
                    sent_d  = '0;
                    rcvd_d  = '0;
                    state_d = (num_ops == 16'd0) ? S_DONE : S_SEND;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    sent_d = sent_q + 16'd1;
                    lfsr_d = lfsr_step(lfsr_q);
                    if (sent_d == num_q) state_d = S_DRAIN;
                end
                outst_d = sent_d - rcvd_d;
                // a presented operand is never withdrawn; a new one loads only when the slot is free
                if (!(op_val_q && !xfer)) begin
                    if ((sent_d < num_q) && (outst_d < MAX_O)) begin
                        op_val_d  = 1'b1;
                        op_data_d = gen_op(mode_q, sent_d, lfsr_d, fixed_q);
                    end else begin
                        op_val_d  = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                op_val_d = 1'b0;
                if (rcvd_q == num_q) state_d = S_DONE;
            end
            default: begin
                op_val_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            num_q     <= '0;
            fixed_q   <= '0;
            lfsr_q    <= LFSR_SEED;
            sent_q    <= '0;
            rcvd_q    <= '0;
            op_val_q  <= 1'b0;
            op_data_q <= '0;
        end else if (sw_rst) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            num_q     <= '0;
            fixed_q   <= '0;
            lfsr_q    <= LFSR_SEED;
            sent_q    <= '0;
            rcvd_q    <= '0;
            op_val_q  <= 1'b0;
            op_data_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            num_q     <= num_d;
            fixed_q   <= fixed_d;
            lfsr_q    <= lfsr_d;
            sent_q    <= sent_d;
            rcvd_q    <= rcvd_d;
            op_val_q  <= op_val_d;
            op_data_q <= op_data_d;
        end
    end

    assign op_val   = op_val_q;
    assign op_data  = op_data_q;
    assign busy     = (state_q == S_SEND) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign ops_sent = sent_q;
    assign res_rcvd = rcvd_q;
endmodule

// File: tb/tb_comp_mult_op_driver.sv
// Bench for comp_mult_op_driver: scoreboard of expected operands, auto result return, runs in every mode.
module tb_comp_mult_op_driver;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic        clk = 1'b0;
    logic        rst, sw_rst, start, op_rdy, sample;
    logic        op_val, busy, done;
    logic [1:0]  mode;
    logic [15:0] num_ops, ops_sent, res_rcvd;
    logic [31:0] fixed_data, op_data;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cap [0:1023];
    int          cyc, hs_cnt, rdy_mode, run_first, run_last, run_base, n0;
    bit          auto_en, man_smp, prev_stall;
    logic [2:0]  pipe;
    logic [31:0] prev_data;

    always #5 clk = ~clk;

    comp_mult_op_driver #(.DWIDTH(8), .MAX_OUTST(4), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .sw_rst(sw_rst), .start(start), .mode(mode),
        .num_ops(num_ops), .fixed_data(fixed_data), .op_val(op_val), .op_rdy(op_rdy),
        .op_data(op_data), .sample(sample), .busy(busy), .done(done),
        .ops_sent(ops_sent), .res_rcvd(res_rcvd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] cor(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h80;
            2'd1:    return 8'h7F;
            2'd2:    return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    // one cycle: drive ready/sample for the next posedge, then observe the handshake
    task automatic step();
        bit hs;
        @(negedge clk);
        cyc++;
        case (rdy_mode)
            0:       op_rdy = 1'b0;
            1:       op_rdy = 1'b1;
            default: op_rdy = 1'($urandom_range(0, 1));
        endcase
        if (prev_stall) begin
            check("hold_val", {31'd0, op_val}, 32'd1);
            check("hold_dat", op_data, prev_data);
        end
        hs         = op_val && op_rdy;
        prev_stall = op_val && !op_rdy;
        prev_data  = op_data;
        if (hs) begin
            if (exp_q.size() == 0) check("unexp_op", 32'd1, 32'd0);
            else                   check("op_data", op_data, exp_q.pop_front());
            cap[hs_cnt % 1024] = op_data;
            if (run_first < 0) run_first = cyc;
            run_last = cyc;
            hs_cnt++;
        end
        pipe   = {pipe[1:0], hs};
        sample = (auto_en && pipe[2]) || man_smp;
    endtask

    task automatic push_exp(input logic [1:0] m, input int n, input logic [31:0] f);
        logic [31:0] l;
        logic [31:0] e;
        logic [7:0]  b;
        l = SEED;
        for (int k = 0; k < n; k++) begin
            b = 8'(k);
            case (m)
                2'd0:    e = l;
                2'd1:    e = {b, b + 8'd1, b + 8'd2, b + 8'd3};
                2'd2:    e = {cor(b[1:0]), cor(b[3:2]), cor(b[5:4]), cor(b[7:6])};
                default: e = f;
            endcase
            exp_q.push_back(e);
            l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
        end
    endtask

    task automatic start_run(input logic [1:0] m, input int n, input logic [31:0] f);
        push_exp(m, n, f);
        mode       = m;
        num_ops    = 16'(n);
        fixed_data = f;
        start      = 1'b1;
        run_first  = -1;
        run_base   = hs_cnt;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int n, input int limit);
        int rc_at;
        bit seen;
        rc_at = -1;
        seen  = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            step();
            if (rc_at < 0 && res_rcvd == 16'(n)) rc_at = cyc;
            if (done) seen = 1'b1;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("done_lag", 32'(cyc - rc_at), 32'd1);
            check("ops_sent", {16'd0, ops_sent}, 32'(n));
            check("res_rcvd", {16'd0, res_rcvd}, 32'(n));
            check("busy_done", {31'd0, busy}, 32'd0);
            check("sb_empty", 32'(exp_q.size()), 32'd0);
            step();
            check("done_pulse", {31'd0, done}, 32'd0);
            check("sent_hold", {16'd0, ops_sent}, 32'(n));
        end
    endtask

    task automatic abort_cleanup();
        exp_q.delete();
        prev_stall = 1'b0;
        pipe       = '0;
        sample     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sw_rst = 1'b0; start = 1'b0; mode = '0; num_ops = '0;
        fixed_data = '0; op_rdy = 1'b0; sample = 1'b0;
        rdy_mode = 0; auto_en = 1'b1; man_smp = 1'b0; pipe = '0; prev_stall = 1'b0;
        prev_data = '0; cyc = 0; hs_cnt = 0; run_first = -1; run_last = 0; run_base = 0;

        repeat (3) step();
        check("rst_val", {31'd0, op_val}, 32'd0);
        check("rst_dat", op_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sent", {16'd0, ops_sent}, 32'd0);
        check("rst_rcvd", {16'd0, res_rcvd}, 32'd0);
        rst = 1'b0;
        step();

        // ramp, always ready: five operands on consecutive cycles
        rdy_mode = 1;
        start_run(2'd1, 5, 32'd0);
        wait_done(5, 100);
        check("ramp_b2b", 32'(run_last - run_first), 32'd4);

        // corner table over a full 256-operand cycle
        start_run(2'd2, 256, 32'd0);
        wait_done(256, 2000);
        check("corner_op0", cap[run_base % 1024], 32'h8080_8080);
        check("corner_op1", cap[(run_base + 1) % 1024], 32'h7F80_8080);
        check("corner_op255", cap[(run_base + 255) % 1024], 32'h0000_0000);

        // LFSR under random backpressure
        rdy_mode = 2;
        start_run(2'd0, 20, 32'd0);
        wait_done(20, 500);

        // fixed pattern; inputs changed mid-run must not matter
        start_run(2'd3, 6, 32'hDEAD_BEEF);
        fixed_data = 32'h1234_5678;
        mode       = 2'd1;
        num_ops    = 16'd2;
        wait_done(6, 300);

        // zero-length run
        rdy_mode = 1;
        n0       = hs_cnt;
        num_ops  = 16'd0;
        start    = 1'b1;
        step();
        start    = 1'b0;
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_val", {31'd0, op_val}, 32'd0);
        step();
        check("zero_pulse", {31'd0, done}, 32'd0);
        check("zero_noops", 32'(hs_cnt - n0), 32'd0);
        check("zero_sent", {16'd0, ops_sent}, 32'd0);

        // start during SEND is ignored
        rdy_mode = 0;
        start_run(2'd1, 3, 32'd0);
        repeat (3) step();
        check("mid_busy", {31'd0, busy}, 32'd1);
        mode    = 2'd3;
        num_ops = 16'd1;
        start   = 1'b1;
        step();
        start   = 1'b0;
        rdy_mode = 1;
        wait_done(3, 100);

        // outstanding cap of 4
        auto_en = 1'b0;
        start_run(2'd1, 10, 32'd0);
        repeat (20) step();
        check("cap_count", 32'(hs_cnt - run_base), 32'd4);
        check("cap_val", {31'd0, op_val}, 32'd0);
        man_smp = 1'b1;
        step();
        man_smp = 1'b0;
        repeat (10) step();
        check("cap_one_more", 32'(hs_cnt - run_base), 32'd5);
        check("cap_val2", {31'd0, op_val}, 32'd0);
        man_smp = 1'b1;
        wait_done(10, 200);
        man_smp = 1'b0;
        auto_en = 1'b1;

        // async reset mid-SEND, then the LFSR sequence restarts from the seed
        rdy_mode = 2;
        start_run(2'd0, 30, 32'd0);
        repeat (10) step();
        rdy_mode = 0;
        for (int i = 0; i < 10 && !op_val; i++) step();
        check("pre_rst_val", {31'd0, op_val}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_val", {31'd0, op_val}, 32'd0);
        check("arst_dat", op_data, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_sent", {16'd0, ops_sent}, 32'd0);
        check("arst_rcvd", {16'd0, res_rcvd}, 32'd0);
        abort_cleanup();
        step();
        step();
        rst = 1'b0;
        step();
        rdy_mode = 2;
        start_run(2'd0, 8, 32'd0);
        wait_done(8, 300);

        // synchronous software reset mid-run
        rdy_mode = 1;
        start_run(2'd1, 50, 32'd0);
        repeat (6) step();
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        check("swrst_busy", {31'd0, busy}, 32'd0);
        check("swrst_val", {31'd0, op_val}, 32'd0);
        check("swrst_sent", {16'd0, ops_sent}, 32'd0);
        check("swrst_rcvd", {16'd0, res_rcvd}, 32'd0);
        abort_cleanup();
        step();
        start_run(2'd1, 5, 32'd0);
        wait_done(5, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
